// File: rtl/alu_iter_if.sv
// Handshake bundle between the EX-stage operand muxes and the iterative ALU.
interface alu_iter_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_0;
    logic [DATA_W-1:0] in_1;
    logic [3:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              of;
    logic              dz;

    modport master (
        output flush, in_valid, in_0, in_1, op, out_ready,
        input  in_ready, out_valid, out, of, dz
    );

    modport slave (
        input  flush, in_valid, in_0, in_1, op, out_ready,
        output in_ready, out_valid, out, of, dz
    );
endinterface

// File: rtl/alu_iter.sv
// Handshaked ALU: logic/add/sub/shift in one cycle, multiply/divide/remainder
// by a DATA_W-step shift-add or restoring-subtract loop.
module alu_iter #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5,
    parameter int CNT_W  = 6
) (
    input  logic      clk,
    input  logic      reset,
    alu_iter_if.slave bus
);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADDS = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_SUBS = 4'd6;
    localparam logic [3:0] OP_SUBU = 4'd7;
    localparam logic [3:0] OP_SHRL = 4'd8;
    localparam logic [3:0] OP_SHLL = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_MULS = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_DIVS = 4'd14;
    localparam logic [3:0] OP_REMS = 4'd15;

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONES_W   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0]   MIN_W    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2*DATA_W-1:0] ZERO_2W  = {(2*DATA_W){1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [3:0]          op_r;
    logic [2*DATA_W-1:0] acc_r, acc_step_s, prod_s;
    logic [DATA_W-1:0]   dvsr_r, out_r;
    logic                neg_r, of_r, dz_r;

    logic              in_ready_s, accept_s, finish_s;
    logic              is_iter_s, is_div_s, is_sgn_s, dz_case_s, ovf_case_s, quick_s;
    logic              a_neg_s, b_neg_s;
    logic [DATA_W-1:0] mag_a_s, mag_b_s, sum_s, diff_s;
    logic [SH_W-1:0]   sh_s;
    logic [DATA_W-1:0] q_out_s, f_out_s;
    logic              q_of_s, q_dz_s, f_of_s;
    logic [DATA_W:0]   mul_sum_s, div_trial_s;

    assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
    assign finish_s   = (state_r == CALC) & (cnt_r == CNT_ONE);

    // Divide-by-zero and MIN/-1 never enter the loop; they resolve like 1-cycle ops.
    assign is_iter_s  = (bus.op >= OP_MULU);
    assign is_div_s   = (bus.op >= OP_DIVU);
    assign is_sgn_s   = (bus.op == OP_MULS) | (bus.op == OP_DIVS) | (bus.op == OP_REMS);
    assign dz_case_s  = is_div_s & (bus.in_1 == ZERO_W);
    assign ovf_case_s = ((bus.op == OP_DIVS) | (bus.op == OP_REMS)) &
                        (bus.in_0 == MIN_W) & (bus.in_1 == ONES_W);
    assign quick_s    = ~is_iter_s | dz_case_s | ovf_case_s;
    assign a_neg_s    = is_sgn_s & bus.in_0[MSB];
    assign b_neg_s    = is_sgn_s & bus.in_1[MSB];
    assign mag_a_s    = a_neg_s ? (ZERO_W - bus.in_0) : bus.in_0;
    assign mag_b_s    = b_neg_s ? (ZERO_W - bus.in_1) : bus.in_1;

    // Result of every op that completes one cycle after accept.
    always_comb begin
        sum_s   = bus.in_0 + bus.in_1;
        diff_s  = bus.in_0 - bus.in_1;
        sh_s    = bus.in_1[SH_W-1:0];
        q_out_s = ZERO_W;
        q_of_s  = 1'b0;
        q_dz_s  = 1'b0;
        case (bus.op)
            OP_NOP:  q_out_s = bus.in_0;
            OP_AND:  q_out_s = bus.in_0 & bus.in_1;
            OP_OR:   q_out_s = bus.in_0 | bus.in_1;
            OP_XOR:  q_out_s = bus.in_0 ^ bus.in_1;
            OP_ADDS: begin
                q_out_s = sum_s;
                q_of_s  = (bus.in_0[MSB] == bus.in_1[MSB]) & (sum_s[MSB] != bus.in_0[MSB]);
            end
            OP_ADDU: {q_of_s, q_out_s} = {1'b0, bus.in_0} + {1'b0, bus.in_1};
            OP_SUBS: begin
                q_out_s = diff_s;
                q_of_s  = (bus.in_0[MSB] != bus.in_1[MSB]) & (diff_s[MSB] != bus.in_0[MSB]);
            end
            OP_SUBU: begin
                q_out_s = diff_s;
                q_of_s  = (bus.in_0 < bus.in_1);
            end
            OP_SHRL: q_out_s = bus.in_0 >> sh_s;
            OP_SHLL: q_out_s = bus.in_0 << sh_s;
            OP_SHRA: q_out_s = $signed(bus.in_0) >>> sh_s;
            default: begin
                if (dz_case_s) begin
                    q_dz_s  = 1'b1;
                    q_out_s = (bus.op == OP_REMS) ? bus.in_0 : ONES_W;
                end else if (ovf_case_s) begin
                    q_out_s = (bus.op == OP_DIVS) ? MIN_W : ZERO_W;
                    q_of_s  = (bus.op == OP_DIVS);
                end else begin
                    q_out_s = ZERO_W;
                end
            end
        endcase
    end

    // acc_r holds {partial product, multiplier} or {partial remainder, quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                      (acc_r[0] ? {1'b0, dvsr_r} : {(DATA_W+1){1'b0}});
        div_trial_s = acc_r[2*DATA_W-1:DATA_W-1] - {1'b0, dvsr_r};
        if (op_r <= OP_MULS) begin
            acc_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end else if (div_trial_s[DATA_W] == 1'b0) begin
            acc_step_s = {div_trial_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
        end else begin
            acc_step_s = {acc_r[2*DATA_W-2:0], 1'b0};
        end
    end

    // Sign fixup and flags applied to the last loop step.
    always_comb begin
        prod_s  = neg_r ? (ZERO_2W - acc_step_s) : acc_step_s;
        f_out_s = ZERO_W;
        f_of_s  = 1'b0;
        case (op_r)
            OP_MULU: begin
                f_out_s = acc_step_s[DATA_W-1:0];
                f_of_s  = (acc_step_s[2*DATA_W-1:DATA_W] != ZERO_W);
            end
            OP_MULS: begin
                f_out_s = prod_s[DATA_W-1:0];
                f_of_s  = (prod_s[2*DATA_W-1:DATA_W] != {DATA_W{prod_s[MSB]}});
            end
            OP_DIVU: f_out_s = acc_step_s[DATA_W-1:0];
            OP_DIVS: f_out_s = neg_r ? (ZERO_W - acc_step_s[DATA_W-1:0]) : acc_step_s[DATA_W-1:0];
            OP_REMS: f_out_s = neg_r ? (ZERO_W - acc_step_s[2*DATA_W-1:DATA_W])
                                     : acc_step_s[2*DATA_W-1:DATA_W];
            default: f_out_s = ZERO_W;
        endcase
    end

    // Next-state logic; flush wins over accept and out_ready.
    always_comb begin
        state_s = state_r;
        if (bus.flush) begin
            state_s = IDLE;
        end else if (accept_s) begin
            state_s = quick_s ? DONE : CALC;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                CALC:    state_s = (cnt_r == CNT_ONE) ? DONE : CALC;
                DONE:    state_s = bus.out_ready ? IDLE : DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iteration datapath: load magnitudes on accept, one step per CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= CNT_ZERO;
            op_r   <= OP_NOP;
            acc_r  <= ZERO_2W;
            dvsr_r <= ZERO_W;
            neg_r  <= 1'b0;
        end else if (bus.flush) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s & ~quick_s) begin
            cnt_r  <= CNT_LOAD;
            op_r   <= bus.op;
            acc_r  <= {ZERO_W, mag_a_s};
            dvsr_r <= mag_b_s;
            neg_r  <= (bus.op == OP_REMS) ? a_neg_s : (a_neg_s ^ b_neg_s);
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= acc_step_s;
        end
    end

    // Result registers change only on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= ZERO_W;
            of_r  <= 1'b0;
            dz_r  <= 1'b0;
        end else if (accept_s & quick_s) begin
            out_r <= q_out_s;
            of_r  <= q_of_s;
            dz_r  <= q_dz_s;
        end else if (finish_s & ~bus.flush) begin
            out_r <= f_out_s;
            of_r  <= f_of_s;
            dz_r  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == DONE);
    assign bus.out       = out_r;
    assign bus.of        = of_r;
    assign bus.dz        = dz_r;
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Keeps the full logic/add/sub/shift op set at 1-cycle registered latency and adds arithmetic right shift plus iterative multiply, divide and remainder.
- Sits in the EX stage between the operand-select muxes and the EX/MEM register; ex_ctrl stalls on in_ready/out_valid.

Parameters:
- DATA_W, 32, operand/result width (>=8, power of 2)
- SH_W, 5, shift-amount width = log2(DATA_W)
- CNT_W, 6, iteration counter width = log2(DATA_W)+1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight/held operation
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- in_0  in  DATA_W  operand A
- in_1  in  DATA_W  operand B / shift amount
- op  in  4  0 NOP,1 AND,2 OR,3 XOR,4 ADDS,5 ADDU,6 SUBS,7 SUBU,8 SHRL,9 SHLL,10 SHRA,11 MULU,12 MULS,13 DIVU,14 DIVS,15 REMS
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out  out  DATA_W  result
- of  out  1  signed/unsigned overflow flag
- dz  out  1  divide-by-zero flag

Behaviour:
- Reset (async, active-high): state=IDLE, out=0, of=0, dz=0, out_valid=0, counter=0. Deasserting reset mid-operation leaves the block in IDLE; no residual result.
- FSM states: IDLE, CALC, DONE. in_ready = (IDLE) | (DONE & out_ready). out_valid = (state==DONE).
- Accept = in_valid & in_ready & !flush. Operands and op are latched on accept; later input changes are ignored.
- Single-cycle ops (0-10), DIV/REM by zero, and DIVS/REMS MIN/-1 go to DONE next cycle (latency 1).
- MULU/MULS/DIVU/DIVS/REMS:
  - go to CALC, counter=DATA_W.
  - One shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements.
  - At counter==1 go to DONE. Latency accept->out_valid = DATA_W+1 cycles.
- DONE holds out/of/dz stable until out_ready. With out_ready=1 and a new accept in the same cycle, the next op is taken with no bubble (back-to-back 1-cycle ops: 1 per clock). With out_ready=1 and no accept, go to IDLE.
- flush: from any state, next state IDLE, out_valid=0; the result is discarded. flush beats accept and beats out_ready in the same cycle.
- Result width and flags:
  - all arithmetic is modulo 2^DATA_W.
  - NOP: out=in_0.
  - Shift amount = in_1[SH_W-1:0]; SHRA sign-fills.
- of flag rules:
  - ADDS: of = sA==sB & sR!=sA.
  - SUBS: of = sA!=sB & sR!=sA.
  - ADDU: of = carry out. SUBU: of = borrow.
  - MULU: out = low half; of = high half != 0.
  - MULS: out = low half; of = full 2*DATA_W product not representable in DATA_W signed.
  - All other ops: of=0.
- Signed divide: computed on magnitudes with sign fixup. Quotient truncates toward zero; remainder takes the dividend's sign.
- DIVS MIN/-1: out=MIN, of=1. REMS MIN/-1: out=0, of=0.
- Divide by zero (in_1==0, ops 13-15): dz=1; DIVU/DIVS out=all-ones; REMS out=in_0. dz=0 for every other case.
- out/of/dz update only on the transition into DONE; they are not cleared on leaving DONE.

Test Plan:
- Reset mid-CALC (MULU 7*9, reset at cycle 5) -> out=0, of=0, dz=0, out_valid=0, in_ready=1 immediately; no out_valid appears afterwards.
- Back-to-back ADDS with out_ready=1: 0x7FFFFFFF+1 then 0x80000000+0xFFFFFFFF -> out_valid on consecutive cycles, out=0x80000000 of=1, then out=0x7FFFFFFF of=1; ADDU 0xFFFFFFFF+1 -> out=0, of=1.
- SHRA 0x80000000 by in_1=0x24 (amount 4) -> out=0xF8000000; SHRL same -> 0x08000000; SHLL 1 by 31 -> 0x80000000.
- MULS 0xFFFFFFFD*0x00000005 -> out_valid exactly 33 cycles after accept, out=0xFFFFFFF1, of=0; MULU 0x00010000*0x00010000 -> out=0, of=1.
- DIVS -7/2 -> out=0xFFFFFFFD; REMS -7/2 -> 0xFFFFFFFF; DIVS 0x80000000/-1 -> 0x80000000, of=1, latency 1; DIVU 5/0 -> 0xFFFFFFFF, dz=1, latency 1.
- Backpressure/flush: DIVU 100/7 with out_ready=0 for 10 cycles -> out=14 held stable, in_ready=0; then assert flush together with out_ready=1 -> out_valid=0 next cycle, state IDLE.
